adc_serial_capture: RTL

//  Per-ADC responder to one start_adcN strobe from the sensor readout sequencer.

---
 rtl/adc_serial_capture.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/adc_serial_capture.sv
// adc_serial_capture: one AD7673 conversion (CNVST pulse, BUSY wait, serial read) per start strobe.
// Build option ADC_OFFSET_SUB_EN adds an offset input, subtracted from each word and saturated at 0.
module adc_serial_capture #(
    parameter int DATA_WIDTH          = 16,
    parameter int INDEX_WIDTH         = 8,
    parameter int CNVST_LOW_CYCLES    = 2,
    parameter int BUSY_TIMEOUT_CYCLES = 250,
    parameter int SCLK_HALF_CYCLES    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   frame_start,
    input  logic                   clear_errors,
    input  logic                   adc_busy,
    input  logic                   adc_sdout,
`ifdef ADC_OFFSET_SUB_EN
    input  logic [DATA_WIDTH-1:0]  offset,
`endif
    output logic                   adc_cnvst_n,
    output logic                   adc_cs_n,
    output logic                   adc_sclk,
    output logic                   sample_valid,
    output logic [DATA_WIDTH-1:0]  sample_data,
    output logic [INDEX_WIDTH-1:0] sample_index,
    output logic                   sample_error,
    output logic                   err_overrun,
    output logic                   err_timeout,
    output logic                   idle
);

    // state     | meaning
    // IDLE      | waiting for start
    // CONV      | adc_cnvst_n held low
    // WAIT_BUSY | waiting for synchronized BUSY to fall, with timeout
    // SHIFT     | adc_cs_n low, clocking DATA_WIDTH bits in MSB first
    // DONE      | sample_valid high for one cycle, index advances
    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_BUSY,
        SHIFT,
        DONE
    } state_t;

    localparam int TMR_W = $clog2(BUSY_TIMEOUT_CYCLES + CNVST_LOW_CYCLES + SCLK_HALF_CYCLES);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [TMR_W-1:0] CNV_LOAD   = TMR_W'(CNVST_LOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LOAD  = TMR_W'(BUSY_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] BLANK_END  = TMR_W'(BUSY_TIMEOUT_CYCLES - 5);
    localparam logic [TMR_W-1:0] HALF_LOAD  = TMR_W'(SCLK_HALF_CYCLES - 1);
    localparam logic [BIT_W-1:0] BITS_LOAD  = BIT_W'(DATA_WIDTH - 1);

    state_t                 state;
    logic [TMR_W-1:0]       timer;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  word_out;
    logic [INDEX_WIDTH-1:0] idx;
    logic                   busy_m;
    logic                   busy_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= adc_busy;
            busy_s <= busy_m;
        end
    end

`ifdef ADC_OFFSET_SUB_EN
    always_comb begin
        word_out = '0;
        if (shift_reg > offset)
            word_out = shift_reg - offset;
    end
`else
    always_comb word_out = shift_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            idx          <= '0;
            adc_cnvst_n  <= 1'b1;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_index <= '0;
            sample_error <= 1'b0;
            err_overrun  <= 1'b0;
            err_timeout  <= 1'b0;
            idle         <= 1'b1;
        end else begin
            sample_valid <= 1'b0;
            if (frame_start)
                idx <= '0;
            // Clears come first so a same-cycle error event below overrides them.
            if (clear_errors) begin
                err_overrun <= 1'b0;
                err_timeout <= 1'b0;
            end
            if (start && state != IDLE)
                err_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CONV;
                        adc_cnvst_n <= 1'b0;
                        idle        <= 1'b0;
                        timer       <= CNV_LOAD;
                    end
                end
                CONV: begin
                    if (timer == '0) begin
                        adc_cnvst_n <= 1'b1;
                        state       <= WAIT_BUSY;
                        timer       <= WAIT_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    // The first four cycles are blanked: BUSY has not yet risen through the synchronizer.
                    if (timer <= BLANK_END && !busy_s) begin
                        state    <= SHIFT;
                        adc_cs_n <= 1'b0;
                        adc_sclk <= 1'b1;
                        timer    <= HALF_LOAD;
                        bit_cnt  <= BITS_LOAD;
                    end else if (timer == '0) begin
                        state        <= DONE;
                        sample_valid <= 1'b1;
                        sample_data  <= '0;
                        sample_index <= idx;
                        sample_error <= 1'b1;
                        err_timeout  <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SHIFT: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        timer <= HALF_LOAD;
                        if (adc_sclk) begin
                            adc_sclk  <= 1'b0;
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], adc_sdout};
                        end else if (bit_cnt == '0) begin
                            adc_cs_n     <= 1'b1;
                            state        <= DONE;
                            sample_valid <= 1'b1;
                            sample_data  <= word_out;
                            sample_index <= idx;
                            sample_error <= 1'b0;
                        end else begin
                            bit_cnt  <= bit_cnt - 1'b1;
                            adc_sclk <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                    if (!frame_start)
                        idx <= idx + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule
